pw_arm_ctrl: RTL and testbench
==============================

// Module: pw_arm_ctrl
// PURPOSE
//  Arming scheduler for the pattern-match / pw_trigger / capture path; single fe_clk domain.
//  Gates the pattern matcher and trigger generator: software arms once for N captures.
//  Re-arms after each capture completes, with programmable holdoff and armed-wait timeout.
//  Reports capture count, done and timeout status to the register block.
// PARAMETERS
//  pCOUNT_WIDTH    8   width of I_num_arms and O_capture_count
//  pHOLDOFF_WIDTH  16  width of I_holdoff (fe_clk cycles between capture end and re-arm)
//  pTIMEOUT_WIDTH  32  width of I_timeout (max fe_clk cycles armed without a match)
// PORTS
//  fe_clk           in   1   sole clock
//  reset_i          in   1   asynchronous, active-high reset
//  I_arm            in   1   1-cycle pulse: start an arming session
//  I_disarm         in   1   1-cycle pulse: abort session
//  I_num_arms       in   pCOUNT_WIDTH    captures per session; 0 = continuous until disarm
//  I_holdoff        in   pHOLDOFF_WIDTH  re-arm holdoff cycles; 0 = immediate
//  I_timeout        in   pTIMEOUT_WIDTH  armed-wait limit; 0 = no timeout
//  I_match          in   1   pattern-match pulse (fe_clk)
//  I_capturing      in   1   capture block busy level
//  O_match_enable   out  1   enables pattern matcher
//  O_trigger_enable out  1   to pw_trigger I_trigger_enable
//  O_armed          out  1   session active (any state but IDLE)
//  O_done_pulse     out  1   1-cycle pulse at session completion (count reached or timeout)
//  O_timeout        out  1   sticky: session ended on timeout; cleared by next accepted I_arm
//  O_capture_count  out  pCOUNT_WIDTH    matches accepted this session; saturates at all-ones
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. All outputs registered.
//  Config inputs are quasi-static: sampled directly, not changed while O_armed.
//  States: IDLE, ARMED, CAPTURE, HOLDOFF, DONE.
//  IDLE: I_arm -> ARMED next cycle; count <= 0, O_timeout <= 0, timeout cnt <= 0.
//    I_arm in any other state is ignored.
//  ARMED: O_match_enable = O_trigger_enable = 1.
//    I_match -> CAPTURE; count++ (saturating); both enables drop next cycle.
//    Else, if I_timeout != 0: tcnt++; tcnt == I_timeout-1 -> O_timeout <= 1, go DONE.
//    Match and timeout expiry in the same cycle: match wins, no timeout.
//  CAPTURE: enables 0; wait for falling edge of I_capturing (registered capturing_r & ~I_capturing).
//    On the edge: if I_num_arms != 0 and count == I_num_arms -> DONE;
//    else if I_holdoff == 0 -> ARMED; else -> HOLDOFF (hcnt <= 0). tcnt <= 0 on every re-arm.
//  HOLDOFF: hcnt++; at hcnt == I_holdoff-1 -> ARMED.
//    Capture end to first enable = I_holdoff+1 cycles; 1 cycle when I_holdoff == 0.
//  DONE: O_done_pulse = 1 for exactly this cycle; -> IDLE. O_capture_count holds until next I_arm.
//  I_disarm: any state -> IDLE next cycle, enables 0 next cycle.
//    Priority over I_match, I_arm and timeout in the same cycle. No O_done_pulse.
//    Count is kept; a capture in flight is not aborted (owned by capture block).
//  Continuous mode (I_num_arms == 0): never enters DONE via count; count saturates, no wrap.
//  reset_i mid-session: immediate return to reset values, no done pulse.
// STRUCTURE
//  pw_trigger_pkg (shared): state localparams (pS_ARM_IDLE..pS_ARM_DONE), default widths.
//  Sub-module pw_arm_counter: clear/enable up-counter with terminal-count compare (== limit-1).
//    Instanced twice: holdoff (pHOLDOFF_WIDTH) and timeout (pTIMEOUT_WIDTH).
//  FSM, saturating count and capturing_r edge detect stay in this module.
// TESTING
//  1 num_arms=3, holdoff=0, three matches each followed by 5-cycle I_capturing -> count 1,2,3;
//    re-arm 1 cycle after each falling edge; O_done_pulse once; O_timeout=0.
//  2 num_arms=2, holdoff=10; match, I_capturing high 4 cycles -> enables reassert exactly
//    11 cycles after the falling edge; a match during holdoff is ignored.
//  3 timeout=100, no match -> O_timeout=1 and O_done_pulse at cycle 100 after arm;
//    match exactly on cycle 100 -> CAPTURE, O_timeout stays 0.
//  4 num_arms=0, pCOUNT_WIDTH=2, 5 matches -> count 1,2,3,3,3; still armed; disarm -> IDLE, no done pulse.
//  5 I_disarm and I_match in the same cycle while ARMED -> IDLE, count unchanged.
//    I_arm while ARMED -> ignored.
//  6 assert reset_i asynchronously mid-HOLDOFF (between clock edges) -> all outputs 0
//    immediately, no clock edge required; after release, I_arm starts a clean session.

Source files
------------

// File: rtl/pw_arm_ctrl_pkg.sv
// Shared types and default widths for the capture arming scheduler.
package pw_arm_ctrl_pkg;

  localparam int unsigned pCOUNT_WIDTH_DEF   = 8;
  localparam int unsigned pHOLDOFF_WIDTH_DEF = 16;
  localparam int unsigned pTIMEOUT_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StCapture,
    StHoldoff,
    StDone
  } arm_st_e;

endpackage

// File: rtl/pw_arm_ctrl_if.sv
// Control/status bundle between the register block and the arming scheduler.
interface pw_arm_ctrl_if
  import pw_arm_ctrl_pkg::*;
#(
  parameter int unsigned pCOUNT_WIDTH   = pCOUNT_WIDTH_DEF,
  parameter int unsigned pHOLDOFF_WIDTH = pHOLDOFF_WIDTH_DEF,
  parameter int unsigned pTIMEOUT_WIDTH = pTIMEOUT_WIDTH_DEF
);
  logic                      I_arm;
  logic                      I_disarm;
  logic [pCOUNT_WIDTH-1:0]   I_num_arms;
  logic [pHOLDOFF_WIDTH-1:0] I_holdoff;
  logic [pTIMEOUT_WIDTH-1:0] I_timeout;
  logic                      I_match;
  logic                      I_capturing;
  logic                      O_match_enable;
  logic                      O_trigger_enable;
  logic                      O_armed;
  logic                      O_done_pulse;
  logic                      O_timeout;
  logic [pCOUNT_WIDTH-1:0]   O_capture_count;

  modport master (
    output I_arm, I_disarm, I_num_arms, I_holdoff, I_timeout, I_match, I_capturing,
    input  O_match_enable, O_trigger_enable, O_armed, O_done_pulse, O_timeout, O_capture_count
  );

  modport slave (
    input  I_arm, I_disarm, I_num_arms, I_holdoff, I_timeout, I_match, I_capturing,
    output O_match_enable, O_trigger_enable, O_armed, O_done_pulse, O_timeout, O_capture_count
  );
endinterface

// File: rtl/pw_arm_ctrl_counter.sv
// Clear/enable up-counter flagging terminal count at limit-1.
module pw_arm_ctrl_counter
  import pw_arm_ctrl_pkg::*;
#(
  parameter int unsigned pWIDTH = pHOLDOFF_WIDTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [pWIDTH-1:0] limit_i,
  output logic              tc_o
);
  logic [pWIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + pWIDTH'(1);
    end
  end

  assign tc_o = (cnt_q == limit_i - pWIDTH'(1));
endmodule

// File: rtl/pw_arm_ctrl.sv
// Arming scheduler: arms the matcher/trigger for N captures with holdoff and armed-wait timeout.
module pw_arm_ctrl
  import pw_arm_ctrl_pkg::*;
#(
  parameter int unsigned pCOUNT_WIDTH   = pCOUNT_WIDTH_DEF,
  parameter int unsigned pHOLDOFF_WIDTH = pHOLDOFF_WIDTH_DEF,
  parameter int unsigned pTIMEOUT_WIDTH = pTIMEOUT_WIDTH_DEF
) (
  input logic          fe_clk,
  input logic          reset_i,
  pw_arm_ctrl_if.slave ctrl_io
);
  arm_st_e                 st_q, st_d;
  logic [pCOUNT_WIDTH-1:0] count_q, count_d;
  logic                    timeout_q, timeout_d;
  logic                    capturing_q;
  logic                    en_q, armed_q, done_q;
  logic                    hold_clr, hold_en, hold_tc;
  logic                    tmo_clr, tmo_en, tmo_tc, tmo_active;
  logic                    cap_fall;

  assign tmo_active = (ctrl_io.I_timeout != '0);
  assign cap_fall   = capturing_q & ~ctrl_io.I_capturing;

  // Both counters sit at zero outside their state, so every entry starts fresh.
  assign hold_clr = (st_q != StHoldoff);
  assign hold_en  = (st_q == StHoldoff);
  assign tmo_clr  = (st_q != StArmed);
  assign tmo_en   = (st_q == StArmed) && !ctrl_io.I_match && tmo_active;

  pw_arm_ctrl_counter #(
    .pWIDTH (pHOLDOFF_WIDTH)
  ) u_holdoff_cnt (
    .clk_i   (fe_clk),
    .rst_i   (reset_i),
    .clr_i   (hold_clr),
    .en_i    (hold_en),
    .limit_i (ctrl_io.I_holdoff),
    .tc_o    (hold_tc)
  );

  pw_arm_ctrl_counter #(
    .pWIDTH (pTIMEOUT_WIDTH)
  ) u_timeout_cnt (
    .clk_i   (fe_clk),
    .rst_i   (reset_i),
    .clr_i   (tmo_clr),
    .en_i    (tmo_en),
    .limit_i (ctrl_io.I_timeout),
    .tc_o    (tmo_tc)
  );

  always_comb begin
    st_d      = st_q;
    count_d   = count_q;
    timeout_d = timeout_q;
    if (ctrl_io.I_disarm) begin
      st_d = StIdle;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (ctrl_io.I_arm) begin
            st_d      = StArmed;
            count_d   = '0;
            timeout_d = 1'b0;
          end
        end
        StArmed: begin
          // Match beats a same-cycle timeout expiry.
          if (ctrl_io.I_match) begin
            st_d = StCapture;
            if (count_q != '1) count_d = count_q + pCOUNT_WIDTH'(1);
          end else if (tmo_active && tmo_tc) begin
            st_d      = StDone;
            timeout_d = 1'b1;
          end
        end
        StCapture: begin
          if (cap_fall) begin
            if (ctrl_io.I_num_arms != '0 && count_q == ctrl_io.I_num_arms) st_d = StDone;
            else if (ctrl_io.I_holdoff == '0)                              st_d = StArmed;
            else                                                           st_d = StHoldoff;
          end
        end
        StHoldoff: begin
          if (hold_tc) st_d = StArmed;
        end
        StDone:  st_d = StIdle;
        default: st_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      st_q        <= StIdle;
      count_q     <= '0;
      timeout_q   <= 1'b0;
      capturing_q <= 1'b0;
      en_q        <= 1'b0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      count_q     <= count_d;
      timeout_q   <= timeout_d;
      capturing_q <= ctrl_io.I_capturing;
      en_q        <= (st_d == StArmed);
      armed_q     <= (st_d != StIdle);
      done_q      <= (st_d == StDone);
    end
  end

  assign ctrl_io.O_match_enable   = en_q;
  assign ctrl_io.O_trigger_enable = en_q;
  assign ctrl_io.O_armed          = armed_q;
  assign ctrl_io.O_done_pulse     = done_q;
  assign ctrl_io.O_timeout        = timeout_q;
  assign ctrl_io.O_capture_count  = count_q;
endmodule

// File: tb/tb_pw_arm_ctrl.sv
// Scoreboard bench for pw_arm_ctrl: expected output events are queued, a negedge monitor checks.
module tb_pw_arm_ctrl;
  localparam int unsigned CW = 2;
  localparam int unsigned HW = 16;
  localparam int unsigned TW = 32;

  logic        fe_clk  = 1'b0;
  logic        reset_i = 1'b1;
  int unsigned cyc     = 0;
  int          vectors = 0;
  int          errors  = 0;

  pw_arm_ctrl_if #(.pCOUNT_WIDTH(CW), .pHOLDOFF_WIDTH(HW), .pTIMEOUT_WIDTH(TW)) bus ();

  pw_arm_ctrl #(
    .pCOUNT_WIDTH   (CW),
    .pHOLDOFF_WIDTH (HW),
    .pTIMEOUT_WIDTH (TW)
  ) dut (
    .fe_clk  (fe_clk),
    .reset_i (reset_i),
    .ctrl_io (bus)
  );

  always #5 fe_clk = ~fe_clk;

  initial forever begin
    @(posedge fe_clk);
    cyc++;
  end

  typedef enum {EvCount, EvEnRise, EvDone, EvArmFall} ev_e;
  typedef struct {
    ev_e         kind;
    int unsigned at;
    int          val;
  } ev_t;

  ev_t exp_q[$];

  function automatic void push_exp(ev_e k, int unsigned at, int val);
    ev_t e;
    e.kind = k;
    e.at   = at;
    e.val  = val;
    exp_q.push_back(e);
  endfunction

  function automatic void observe(ev_e k, int v);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s@%0d val %0d, required no event", k.name(), cyc, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.at != cyc || e.val != v) begin
        errors++;
        $display("FAIL event_%s: got %s@%0d val %0d, required %s@%0d val %0d",
                 e.kind.name(), k.name(), cyc, v, e.kind.name(), e.at, e.val);
      end
    end
  endfunction

  function automatic void check(string name, int act, int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endfunction

  // Monitor: turns output changes into events and checks them against the queue.
  initial begin
    logic [CW-1:0] prev_cnt;
    logic          prev_en, prev_armed;
    prev_cnt   = '0;
    prev_en    = 1'b0;
    prev_armed = 1'b0;
    forever begin
      @(negedge fe_clk);
      if (bus.O_capture_count != prev_cnt)     observe(EvCount, int'(bus.O_capture_count));
      if (bus.O_match_enable && !prev_en)      observe(EvEnRise, int'(bus.O_trigger_enable));
      if (bus.O_done_pulse)                    observe(EvDone, int'(bus.O_timeout));
      if (!bus.O_armed && prev_armed)          observe(EvArmFall, int'(bus.O_match_enable));
      prev_cnt   = bus.O_capture_count;
      prev_en    = bus.O_match_enable;
      prev_armed = bus.O_armed;
    end
  end

  task automatic tick();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic pulse_arm();
    bus.I_arm = 1'b1;
    tick();
    bus.I_arm = 1'b0;
  endtask

  task automatic pulse_disarm();
    bus.I_disarm = 1'b1;
    tick();
    bus.I_disarm = 1'b0;
  endtask

  // Match pulse, then I_capturing high for hi cycles; returns on the cycle it is driven low.
  task automatic match_capture(input int hi);
    bus.I_match = 1'b1;
    tick();
    bus.I_match     = 1'b0;
    bus.I_capturing = 1'b1;
    repeat (hi) tick();
    bus.I_capturing = 1'b0;
  endtask

  initial begin
    int unsigned a, m, d;
    ev_t         e;
    bus.I_arm       = 1'b0;
    bus.I_disarm    = 1'b0;
    bus.I_num_arms  = '0;
    bus.I_holdoff   = '0;
    bus.I_timeout   = '0;
    bus.I_match     = 1'b0;
    bus.I_capturing = 1'b0;
    #2;
    check("reset_state", int'({bus.O_capture_count, bus.O_match_enable, bus.O_trigger_enable,
                                bus.O_armed, bus.O_done_pulse, bus.O_timeout}), 0);
    repeat (3) tick();
    reset_i = 1'b0;
    repeat (2) tick();

    // 1: three captures, no holdoff
    bus.I_num_arms = 2'd3;
    a = cyc;
    push_exp(EvEnRise, a + 1, 1);
    pulse_arm();
    tick();
    for (int k = 0; k < 3; k++) begin
      m = cyc;
      push_exp(EvCount, m + 1, k + 1);
      if (k < 2) begin
        push_exp(EvEnRise, m + 7, 1);
      end else begin
        push_exp(EvDone, m + 7, 0);
        push_exp(EvArmFall, m + 8, 0);
      end
      match_capture(5);
      tick();
    end
    repeat (2) tick();
    check("t1_count_hold", int'(bus.O_capture_count), 3);

    // 2: holdoff 10, match during holdoff ignored
    bus.I_num_arms = 2'd2;
    bus.I_holdoff  = 16'd10;
    a = cyc;
    push_exp(EvCount, a + 1, 0);
    push_exp(EvEnRise, a + 1, 1);
    pulse_arm();
    tick();
    m = cyc;
    push_exp(EvCount, m + 1, 1);
    push_exp(EvEnRise, m + 16, 1);
    match_capture(4);
    repeat (3) tick();
    bus.I_match = 1'b1;
    tick();
    bus.I_match = 1'b0;
    repeat (9) tick();
    m = cyc;
    push_exp(EvCount, m + 1, 2);
    push_exp(EvDone, m + 6, 0);
    push_exp(EvArmFall, m + 7, 0);
    match_capture(4);
    repeat (3) tick();

    // 3: timeout 100
    bus.I_holdoff = '0;
    bus.I_timeout = 32'd100;
    a = cyc;
    push_exp(EvCount, a + 1, 0);
    push_exp(EvEnRise, a + 1, 1);
    push_exp(EvDone, a + 101, 1);
    push_exp(EvArmFall, a + 102, 0);
    pulse_arm();
    repeat (105) tick();
    check("t3_timeout_sticky", int'(bus.O_timeout), 1);
    a = cyc;
    push_exp(EvEnRise, a + 1, 1);
    pulse_arm();
    check("t3_timeout_cleared", int'(bus.O_timeout), 0);
    repeat (99) tick();
    push_exp(EvCount, a + 101, 1);
    bus.I_match = 1'b1;
    tick();
    bus.I_match = 1'b0;
    tick();
    check("t3_match_wins", int'({bus.O_timeout, bus.O_armed, bus.O_match_enable}), 2);
    d = cyc;
    push_exp(EvArmFall, d + 1, 0);
    pulse_disarm();
    bus.I_timeout = '0;
    tick();

    // 4: continuous mode, count saturates at 3
    bus.I_num_arms = '0;
    a = cyc;
    push_exp(EvCount, a + 1, 0);
    push_exp(EvEnRise, a + 1, 1);
    pulse_arm();
    tick();
    for (int k = 0; k < 5; k++) begin
      m = cyc;
      if (k < 3) push_exp(EvCount, m + 1, k + 1);
      push_exp(EvEnRise, m + 4, 1);
      match_capture(2);
      tick();
    end
    check("t4_still_armed", int'(bus.O_armed), 1);
    d = cyc;
    push_exp(EvArmFall, d + 1, 0);
    pulse_disarm();
    repeat (3) tick();
    check("t4_count_kept", int'(bus.O_capture_count), 3);

    // 5: disarm beats match; arm while armed ignored
    a = cyc;
    push_exp(EvCount, a + 1, 0);
    push_exp(EvEnRise, a + 1, 1);
    pulse_arm();
    tick();
    m = cyc;
    push_exp(EvCount, m + 1, 1);
    push_exp(EvEnRise, m + 4, 1);
    match_capture(2);
    tick();
    pulse_arm();
    tick();
    d = cyc;
    push_exp(EvArmFall, d + 1, 0);
    bus.I_disarm = 1'b1;
    bus.I_match  = 1'b1;
    tick();
    bus.I_disarm = 1'b0;
    bus.I_match  = 1'b0;
    tick();
    check("t5_count_unchanged", int'(bus.O_capture_count), 1);
    check("t5_enables_off", int'({bus.O_match_enable, bus.O_trigger_enable, bus.O_armed}), 0);

    // 6: asynchronous reset mid-holdoff
    bus.I_num_arms = 2'd2;
    bus.I_holdoff  = 16'd20;
    a = cyc;
    push_exp(EvCount, a + 1, 0);
    push_exp(EvEnRise, a + 1, 1);
    pulse_arm();
    tick();
    m = cyc;
    push_exp(EvCount, m + 1, 1);
    match_capture(2);
    repeat (5) tick();
    #2;
    push_exp(EvCount, cyc, 0);
    push_exp(EvArmFall, cyc, 0);
    reset_i = 1'b1;
    #1;
    check("t6_async_reset", int'({bus.O_capture_count, bus.O_match_enable, bus.O_trigger_enable,
                                  bus.O_armed, bus.O_done_pulse, bus.O_timeout}), 0);
    repeat (2) tick();
    reset_i = 1'b0;
    tick();
    a = cyc;
    push_exp(EvEnRise, a + 1, 1);
    pulse_arm();
    check("t6_clean_session", int'({bus.O_armed, bus.O_match_enable, bus.O_capture_count,
                                    bus.O_timeout}), 24);
    d = cyc;
    push_exp(EvArmFall, d + 1, 0);
    pulse_disarm();
    repeat (5) tick();

    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      errors++;
      $display("FAIL missing_event: got nothing, required %s@%0d val %0d", e.kind.name(), e.at,
               e.val);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
